// File: rtl/sr_flop_bank.sv
// sr_flop_bank: WIDTH independent edge-triggered storage bits with a runtime
// mode select (SR / JK / D / T), a deterministic S=R=1 policy for SR mode and
// forbidden-input status flags.
//
// Optional feature macro: SR_ILLEGAL_CNT_EN
//   defined   -> adds the illegal_cnt port, a saturating count of cycles in
//                which any bit saw S=R=1 in SR mode.
//   undefined -> no counter port or logic; everything else is identical.
//
// Reset is synchronous and active-low; it overrides en, mode and clr_sticky.
module sr_flop_bank #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned       SR_POLICY = 0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             illegal,
  output logic             illegal_sticky,
  input  logic             clr_sticky
`ifdef SR_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  // Operating modes as encoded on the mode input.
  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  // S=R=1 resolution policies; anything outside 0..2 falls back to hold.
  localparam logic [1:0] POL_HOLD  = 2'd0;
  localparam logic [1:0] POL_SET   = 2'd1;
  localparam logic [1:0] POL_RESET = 2'd2;
  localparam logic [1:0] POLICY_EFF =
    (SR_POLICY == 32'd1) ? POL_SET :
    (SR_POLICY == 32'd2) ? POL_RESET : POL_HOLD;

  // Configuration range guard, evaluated at elaboration.
  if (WIDTH < 32'd1 || WIDTH > 32'd32 || CNT_W < 32'd1) begin : g_param_range_error
    $error("sr_flop_bank: WIDTH must be 1..32 and CNT_W at least 1");
  end

  // Next value of one SR bit; the S=R=1 case follows the fixed policy.
  function automatic logic sr_next_bit(input logic q_b, input logic s_b, input logic r_b);
    logic nxt;
    case ({s_b, r_b})
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      2'b00:   nxt = q_b;
      2'b11: begin
        case (POLICY_EFF)
          POL_SET:   nxt = 1'b1;
          POL_RESET: nxt = 1'b0;
          POL_HOLD:  nxt = q_b;
          default:   nxt = q_b;
        endcase
      end
      default: nxt = q_b;
    endcase
    return nxt;
  endfunction

  // Next value of one JK bit: J=K=1 toggles.
  function automatic logic jk_next_bit(input logic q_b, input logic j_b, input logic k_b);
    logic nxt;
    case ({j_b, k_b})
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      2'b00:   nxt = q_b;
      2'b11:   nxt = ~q_b;
      default: nxt = q_b;
    endcase
    return nxt;
  endfunction

  // Next value of one T bit: the r input is a synchronous clear that beats toggle.
  function automatic logic t_next_bit(input logic q_b, input logic t_b, input logic c_b);
    logic nxt;
    if (c_b) begin
      nxt = 1'b0;
    end else if (t_b) begin
      nxt = ~q_b;
    end else begin
      nxt = q_b;
    end
    return nxt;
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             illegal_r;
  logic             sticky_r;
  logic             event_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Per-bit next-state selection for the active mode; en=0 holds every bit.
  always_comb begin
    q_next_s = q_r;
    if (en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        case (mode_s)
          MODE_SR: q_next_s[i] = sr_next_bit(q_r[i], s[i], r[i]);
          MODE_JK: q_next_s[i] = jk_next_bit(q_r[i], s[i], r[i]);
          MODE_D:  q_next_s[i] = s[i];
          MODE_T:  q_next_s[i] = t_next_bit(q_r[i], s[i], r[i]);
          default: q_next_s[i] = q_r[i];
        endcase
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Forbidden-input detection: any bit with S=R=1 while updating in SR mode.
  always_comb begin
    event_s = 1'b0;
    if (en && (mode_s == MODE_SR)) begin
      event_s = |(s & r);
    end else begin
      event_s = 1'b0;
    end
  end

  // Storage bits and status flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r       <= RESET_VAL;
      illegal_r <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      q_r       <= q_next_s;
      illegal_r <= event_s;
      if (event_s) begin
        sticky_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_r <= 1'b0;
      end else begin
        sticky_r <= sticky_r;
      end
    end
  end

`ifdef SR_ILLEGAL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Saturating count of illegal cycles; a clear coinciding with an event restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr_sticky) begin
      cnt_r <= event_s ? CNT_ONE : CNT_ZERO;
    end else if (event_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign illegal_cnt = cnt_r;
`endif

  assign q              = q_r;
  assign qbar           = ~q_r;
  assign illegal        = illegal_r;
  assign illegal_sticky = sticky_r;

endmodule
